// File: rtl/ldst_vaddr_arbiter_if.sv
// ----------------------------------------------------------------------------
// ldst_vaddr_pkg / ldst_vaddr_arbiter_if
//
// Purpose
//   ldst_vaddr_pkg holds the shared widths and access/exception types used
//   by the load/store virtual-address path.
//
//   ldst_vaddr_arbiter_if bundles every handshake and bus signal around the
//   virtual-address arbiter. It carries:
//     - the load-buffer (lb_*) and store-buffer (sb_*) request channels
//     - the single request channel towards the address adder
//     - the adder result channel and its demultiplexed copy back to LB/SB
//     - the synchronous pipeline flush
//
// Modports
//   slave  : the arbiter's view. It receives requests, flush and results.
//            It drives the ready signals, the adder request register and
//            the result demux.
//   master : the surrounding pipeline's view (LB, SB, adder, flush source).
//
// Handshake rule (all channels)
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. A producer holding valid keeps its payload stable until the
//   transfer. Ready may only be high while the matching valid is high.
// ----------------------------------------------------------------------------
package ldst_vaddr_pkg;

    localparam int XLEN  = 64;
    localparam int I_IMM = 12;

    typedef enum logic [2:0] {
        LS_BYTE              = 3'd0,
        LS_HALFWORD          = 3'd1,
        LS_WORD              = 3'd2,
        LS_DOUBLEWORD        = 3'd3,
        LS_BYTE_UNSIGNED     = 3'd4,
        LS_HALFWORD_UNSIGNED = 3'd5,
        LS_WORD_UNSIGNED     = 3'd6
    } ldst_type_t;

    typedef enum logic [1:0] {
        VADDER_NO_EXCEPT    = 2'd0,
        VADDER_ALIGN_EXCEPT = 2'd1,
        VADDER_PAGE_EXCEPT  = 2'd2
    } vadder_except_t;

endpackage

interface ldst_vaddr_arbiter_if #(
    parameter int IDX_LEN = 8
) ();

    // Pipeline flush, synchronous to the arbiter clock.
    logic                              flush;

    // Load-buffer request channel.
    logic                              lb_valid;
    logic                              lb_ready;
    logic [ldst_vaddr_pkg::XLEN-1:0]   lb_rs1_value;
    logic [ldst_vaddr_pkg::I_IMM-1:0]  lb_imm_value;
    logic [IDX_LEN-1:0]                lb_idx;
    ldst_vaddr_pkg::ldst_type_t        lb_ldst_type;

    // Store-buffer request channel.
    logic                              sb_valid;
    logic                              sb_ready;
    logic [ldst_vaddr_pkg::XLEN-1:0]   sb_rs1_value;
    logic [ldst_vaddr_pkg::I_IMM-1:0]  sb_imm_value;
    logic [IDX_LEN-1:0]                sb_idx;
    ldst_vaddr_pkg::ldst_type_t        sb_ldst_type;

    // Registered request towards the address adder.
    logic                              adder_valid;
    logic                              adder_ready;
    logic                              is_store;
    logic [ldst_vaddr_pkg::XLEN-1:0]   rs1_value;
    logic [ldst_vaddr_pkg::I_IMM-1:0]  imm_value;
    logic [IDX_LEN-1:0]                lsb_idx;
    ldst_vaddr_pkg::ldst_type_t        ldst_type;

    // Result coming back from the adder.
    logic                              res_valid;
    logic                              res_is_store;
    logic [ldst_vaddr_pkg::XLEN-1:0]   res_vaddr;
    logic [IDX_LEN-1:0]                res_idx;
    ldst_vaddr_pkg::vadder_except_t    res_except;

    // Result steered back to LB or SB; payload shared by both.
    logic                              lb_res_valid;
    logic                              sb_res_valid;
    logic [ldst_vaddr_pkg::XLEN-1:0]   lsb_res_vaddr;
    logic [IDX_LEN-1:0]                lsb_res_idx;
    ldst_vaddr_pkg::vadder_except_t    lsb_res_except;

    modport slave (
        input  flush,
        input  lb_valid, lb_rs1_value, lb_imm_value, lb_idx, lb_ldst_type,
        output lb_ready,
        input  sb_valid, sb_rs1_value, sb_imm_value, sb_idx, sb_ldst_type,
        output sb_ready,
        output adder_valid, is_store, rs1_value, imm_value, lsb_idx, ldst_type,
        input  adder_ready,
        input  res_valid, res_is_store, res_vaddr, res_idx, res_except,
        output lb_res_valid, sb_res_valid, lsb_res_vaddr, lsb_res_idx, lsb_res_except
    );

    modport master (
        output flush,
        output lb_valid, lb_rs1_value, lb_imm_value, lb_idx, lb_ldst_type,
        input  lb_ready,
        output sb_valid, sb_rs1_value, sb_imm_value, sb_idx, sb_ldst_type,
        input  sb_ready,
        input  adder_valid, is_store, rs1_value, imm_value, lsb_idx, ldst_type,
        output adder_ready,
        output res_valid, res_is_store, res_vaddr, res_idx, res_except,
        input  lb_res_valid, sb_res_valid, lsb_res_vaddr, lsb_res_idx, lsb_res_except
    );

endinterface

// File: rtl/ldst_vaddr_arbiter.sv
// ----------------------------------------------------------------------------
// ldst_vaddr_arbiter
//
// Purpose
//   Arbitrates address-computation requests from the load buffer and the
//   store buffer into the single virtual-address adder. The winner is held
//   in a one-entry output register with a valid/ready handshake towards the
//   adder. Loads win by default. A starvation counter bounds how many
//   consecutive loads may pass a waiting store, so stores always progress.
//   The adder result is steered back to LB or SB with zero latency.
//
// Parameters
//   IDX_LEN    : width of the LB/SB entry index. It must match the IDX_LEN
//                of the connected interface instance.
//   STARVE_MAX : maximum number of consecutive load grants while a store is
//                waiting. Must be at least 1.
//
// Ports
//   clk_i      : clock
//   rst_n_i    : asynchronous, active-low reset
//   bus        : ldst_vaddr_arbiter_if.slave. It carries the LB/SB request
//                channels, the adder request and result channels, the
//                result demux and the flush.
//   starve_cnt : current starvation count, exposed for observation
//
// Handshake rule
//   A transfer happens on a rising edge with valid and ready both high.
//   lb_ready/sb_ready are asserted only for the granted, valid requester.
//   They are asserted when the output register can take a new entry: it is
//   either empty, or being drained by the adder in the same cycle.
//   The output register holds stable while adder_valid is high and
//   adder_ready is low.
// ----------------------------------------------------------------------------
module ldst_vaddr_arbiter
    import ldst_vaddr_pkg::*;
#(
    parameter  int IDX_LEN    = 8,
    parameter  int STARVE_MAX = 4,
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    ldst_vaddr_arbiter_if.slave bus,
    output logic [CNT_W-1:0] starve_cnt
);

    // ------------------------------------------------------------------
    // Request register contents
    // ------------------------------------------------------------------
    typedef struct packed {
        logic               is_store;
        logic [XLEN-1:0]    rs1_value;
        logic [I_IMM-1:0]   imm_value;
        logic [IDX_LEN-1:0] idx;
        ldst_type_t         ldst_type;
    } req_t;

    localparam req_t REQ_RESET = '{
        is_store:  1'b0,
        rs1_value: '0,
        imm_value: '0,
        idx:       '0,
        ldst_type: LS_DOUBLEWORD
    };

    logic             req_valid_q;
    req_t             req_q;
    logic [CNT_W-1:0] starve_cnt_q;

    // ------------------------------------------------------------------
    // Grant and ready
    // ------------------------------------------------------------------
    logic can_accept;
    logic starved;
    logic grant_lb;
    logic grant_sb;
    logic lb_take;
    logic sb_take;
    req_t req_next;

    always_comb begin
        can_accept = 1'b0;
        starved    = 1'b0;
        grant_sb   = 1'b0;
        grant_lb   = 1'b0;
        lb_take    = 1'b0;
        sb_take    = 1'b0;
        req_next   = REQ_RESET;

        // An entry leaving towards the adder frees the slot in the same
        // cycle, so issue continues back-to-back without a bubble.
        can_accept = !req_valid_q || bus.adder_ready;

        // A store that has already watched STARVE_MAX loads go ahead takes
        // the next grant, even against a valid load.
        starved  = (starve_cnt_q == CNT_W'(STARVE_MAX));
        grant_sb = bus.sb_valid && (!bus.lb_valid || starved);
        grant_lb = bus.lb_valid && !grant_sb;

        // No grant is taken in a flush cycle. The requester keeps valid
        // and retries after the flush.
        lb_take = grant_lb && can_accept && !bus.flush;
        sb_take = grant_sb && can_accept && !bus.flush;

        if (grant_sb) begin
            req_next.is_store  = 1'b1;
            req_next.rs1_value = bus.sb_rs1_value;
            req_next.imm_value = bus.sb_imm_value;
            req_next.idx       = bus.sb_idx;
            req_next.ldst_type = bus.sb_ldst_type;
        end else begin
            req_next.is_store  = 1'b0;
            req_next.rs1_value = bus.lb_rs1_value;
            req_next.imm_value = bus.lb_imm_value;
            req_next.idx       = bus.lb_idx;
            req_next.ldst_type = bus.lb_ldst_type;
        end
    end

    // ------------------------------------------------------------------
    // Output request register
    // Priority: flush > accept (which also covers a simultaneous drain) >
    // drain > hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_valid_q <= 1'b0;
            req_q       <= REQ_RESET;
        end else if (bus.flush) begin
            req_valid_q <= 1'b0;
            req_q       <= REQ_RESET;
        end else if (lb_take || sb_take) begin
            req_valid_q <= 1'b1;
            req_q       <= req_next;
        end else if (bus.adder_ready) begin
            // The payload is left in place after a drain. Only valid drops.
            req_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter
    // The counter counts loads that overtook a waiting store. It restarts
    // whenever no store is waiting or a store is finally granted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt_q <= '0;
        end else if (bus.flush || !bus.sb_valid || sb_take) begin
            starve_cnt_q <= '0;
        end else if (lb_take && !starved) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end

    assign starve_cnt = starve_cnt_q;

    // ------------------------------------------------------------------
    // Interface outputs: ready and adder request
    // ------------------------------------------------------------------
    assign bus.lb_ready    = lb_take;
    assign bus.sb_ready    = sb_take;
    assign bus.adder_valid = req_valid_q;
    assign bus.is_store    = req_q.is_store;
    assign bus.rs1_value   = req_q.rs1_value;
    assign bus.imm_value   = req_q.imm_value;
    assign bus.lsb_idx     = req_q.idx;
    assign bus.ldst_type   = req_q.ldst_type;

    // ------------------------------------------------------------------
    // Result demux
    // The payload goes to both buffers. Only the valid is steered.
    // A result arriving during a flush belongs to squashed work, so it
    // is dropped.
    // ------------------------------------------------------------------
    assign bus.lb_res_valid   = bus.res_valid && !bus.res_is_store && !bus.flush;
    assign bus.sb_res_valid   = bus.res_valid &&  bus.res_is_store && !bus.flush;
    assign bus.lsb_res_vaddr  = bus.res_vaddr;
    assign bus.lsb_res_idx    = bus.res_idx;
    assign bus.lsb_res_except = bus.res_except;

endmodule
